// File: rtl/counter_bidir_bank.sv
// Bank of C_CH independent up/down counters with load and registered zero/full/almost-full/error flags.
// Define COUNTER_BANK_SAT_EN to clamp at 0/C_MAX with a sticky error flag; otherwise counts wrap.
module counter_bidir_bank #(
    parameter int C_CH    = 4,
    parameter int C_W     = 8,
    parameter int C_INC_W = 2,
    parameter int C_INIT  = 0,
    parameter int C_MAX   = (1 << C_W) - 1,
    parameter int C_AFULL = C_MAX - 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_CH-1:0]         load_i,
    input  logic [C_CH*C_W-1:0]     load_value_i,
    input  logic [C_CH*C_INC_W-1:0] incr_i,
    input  logic [C_CH*C_INC_W-1:0] decr_i,
    input  logic [C_CH-1:0]         err_clr_i,
    output logic [C_CH*C_W-1:0]     count_o,
    output logic [C_CH-1:0]         is_zero_o,
    output logic [C_CH-1:0]         is_full_o,
    output logic [C_CH-1:0]         afull_o,
    output logic [C_CH-1:0]         err_o
);

    localparam int              PAD     = C_W + 2 - C_INC_W;
    localparam logic [C_W-1:0]  INIT_V  = C_W'(C_INIT);
    localparam logic [C_W-1:0]  MAX_V   = C_W'(C_MAX);
    localparam logic [C_W-1:0]  AFULL_V = C_W'(C_AFULL);
    localparam logic            ZERO_R  = (C_INIT == 0);
    localparam logic            FULL_R  = (C_INIT == C_MAX);
    localparam logic            AFULL_R = (C_INIT >= C_AFULL);

    // Declaration initialisers mirror the reset values for FPGA bring-up without reset.
    logic [C_CH*C_W-1:0] count_q = {C_CH{INIT_V}};
    logic [C_CH-1:0]     zero_q  = {C_CH{ZERO_R}};
    logic [C_CH-1:0]     full_q  = {C_CH{FULL_R}};
    logic [C_CH-1:0]     afull_q = {C_CH{AFULL_R}};
    logic [C_CH-1:0]     err_q   = '0;

    logic [C_CH*C_W-1:0] count_d;
    logic [C_CH-1:0]     zero_d, full_d, afull_d, err_d;

    logic [C_W-1:0]        ld_v, cur_v, nxt_v;
    logic signed [C_W+1:0] sum_s;
`ifdef COUNTER_BANK_SAT_EN
    logic                  ovf;
`else
    logic                  unused_bits;
    assign unused_bits = ^{err_clr_i, sum_s[C_W+1:C_W]};
`endif

    always_comb begin
        count_d = count_q;
        zero_d  = zero_q;
        full_d  = full_q;
        afull_d = afull_q;
        err_d   = '0;
        ld_v    = '0;
        cur_v   = '0;
        nxt_v   = '0;
        sum_s   = '0;
`ifdef COUNTER_BANK_SAT_EN
        ovf     = 1'b0;
`endif
        for (int k = 0; k < C_CH; k++) begin
            ld_v  = load_value_i[k*C_W +: C_W];
            cur_v = count_q[k*C_W +: C_W];
            // Two guard bits keep count+incr-decr exact before clamp or wrap.
            sum_s = $signed({2'b00, cur_v})
                  + $signed({{PAD{1'b0}}, incr_i[k*C_INC_W +: C_INC_W]})
                  - $signed({{PAD{1'b0}}, decr_i[k*C_INC_W +: C_INC_W]});
`ifdef COUNTER_BANK_SAT_EN
            ovf = 1'b0;
            if (load_i[k]) begin
                if (ld_v > MAX_V) begin
                    nxt_v = MAX_V;
                    ovf   = 1'b1;
                end else begin
                    nxt_v = ld_v;
                end
            end else if (sum_s < 0) begin
                nxt_v = '0;
                ovf   = 1'b1;
            end else if (sum_s > $signed({2'b00, MAX_V})) begin
                nxt_v = MAX_V;
                ovf   = 1'b1;
            end else begin
                nxt_v = sum_s[C_W-1:0];
            end
            // A new event in the same cycle as a clear keeps the flag set.
            err_d[k] = ovf | (err_q[k] & ~err_clr_i[k]);
`else
            nxt_v = load_i[k] ? ld_v : sum_s[C_W-1:0];
`endif
            count_d[k*C_W +: C_W] = nxt_v;
            zero_d[k]  = (nxt_v == '0);
            full_d[k]  = (nxt_v == MAX_V);
            afull_d[k] = (nxt_v >= AFULL_V);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {C_CH{INIT_V}};
            zero_q  <= {C_CH{ZERO_R}};
            full_q  <= {C_CH{FULL_R}};
            afull_q <= {C_CH{AFULL_R}};
            err_q   <= '0;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            err_q   <= err_d;
        end
    end

    assign count_o   = count_q;
    assign is_zero_o = zero_q;
    assign is_full_o = full_q;
    assign afull_o   = afull_q;
    assign err_o     = err_q;

endmodule
